// File: rtl/usb4_ser_pkg.sv
// Shared constants, gen_speed encodings and FSM state type for the lane serializer.
// sym_len() maps a gen_speed code to the symbol length in bits.
package usb4_ser_pkg;

    localparam logic [7:0] SYM_LEN_GEN2 = 8'd66;
    localparam logic [7:0] SYM_LEN_GEN1 = 8'd132;
    localparam logic [7:0] SYM_LEN_GEN0 = 8'd8;

    localparam logic [1:0] GEN_SPEED_GEN0     = 2'd0;
    localparam logic [1:0] GEN_SPEED_GEN1     = 2'd1;
    localparam logic [1:0] GEN_SPEED_GEN2     = 2'd2;
    localparam logic [1:0] GEN_SPEED_GEN2_ALT = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Code 3 is an alias of Gen2, so it falls into the default arm.
    function automatic logic [7:0] sym_len(input logic [1:0] gen);
        logic [7:0] len_s;
        case (gen)
            GEN_SPEED_GEN0: len_s = SYM_LEN_GEN0;
            GEN_SPEED_GEN1: len_s = SYM_LEN_GEN1;
            default:        len_s = SYM_LEN_GEN2;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// One lane: a one-deep holding buffer feeding an LSB-first shift register.
// ser_bit is the shift register's bit 0, so the serial output is registered.
module lane_shift_reg #(
    parameter int MAX_SYM = 132
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_en,
    input  logic               load,
    input  logic               shift,
    input  logic               clear,
    input  logic [MAX_SYM-1:0] sym_in,
    output logic               ser_bit
);

    logic [MAX_SYM-1:0] buf_r;
    logic [MAX_SYM-1:0] shift_r;

    // Holding buffer: captures the symbol on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r <= {MAX_SYM{1'b0}};
        end else if (flush) begin
            buf_r <= {MAX_SYM{1'b0}};
        end else if (wr_en) begin
            buf_r <= sym_in;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Shift register: load from buffer, shift right, or clear when going idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {MAX_SYM{1'b0}};
        end else if (flush) begin
            shift_r <= {MAX_SYM{1'b0}};
        end else if (load) begin
            shift_r <= buf_r;
        end else if (shift) begin
            shift_r <= {1'b0, shift_r[MAX_SYM-1:1]};
        end else if (clear) begin
            shift_r <= {MAX_SYM{1'b0}};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign ser_bit = shift_r[0];

endmodule

// File: rtl/lane_serializer.sv
// Two-lane parallel-to-serial stage: one control FSM and bit counter drive two
// lane_shift_reg instances; symbols stream back-to-back with underrun detection.
module lane_serializer
    import usb4_ser_pkg::*;
#(
    parameter int MAX_SYM = 132
) (
    input  logic               ser_clk,
    input  logic               rst,
    input  logic               enable_ser,
    input  logic [1:0]         gen_speed,
    input  logic [MAX_SYM-1:0] lane_0_tx_enc_old,
    input  logic [MAX_SYM-1:0] lane_1_tx_enc_old,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic               lane_0_ser,
    output logic               lane_1_ser,
    output logic               ser_active,
    output logic               underrun
);

    ser_state_e state_r;
    logic       buf_full_r;
    logic [7:0] buf_len_r;
    logic [7:0] cur_len_r;
    logic [7:0] bit_cnt_r;
    logic       ser_active_r;
    logic       underrun_r;

    logic       accept_s;
    logic       last_bit_s;
    logic       load_s;
    logic       shift_s;
    logic       clear_s;
    logic       flush_s;

    assign flush_s    = ~enable_ser;
    assign sym_ready  = enable_ser & ~buf_full_r;
    assign accept_s   = sym_valid & sym_ready;
    assign last_bit_s = (bit_cnt_r == (cur_len_r - 8'd1));

    // Per-edge datapath strobes derived from the current FSM state.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (buf_full_r) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    if (buf_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        clear_s = 1'b1;
                    end
                end else begin
                    shift_s = 1'b1;
                end
            end
            default: clear_s = 1'b1;
        endcase
    end

    // Control FSM, buffer bookkeeping, bit counter and registered status flags.
    always_ff @(posedge ser_clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            buf_full_r   <= 1'b0;
            buf_len_r    <= 8'd0;
            cur_len_r    <= 8'd0;
            bit_cnt_r    <= 8'd0;
            ser_active_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else if (flush_s) begin
            state_r      <= IDLE;
            buf_full_r   <= 1'b0;
            buf_len_r    <= 8'd0;
            cur_len_r    <= 8'd0;
            bit_cnt_r    <= 8'd0;
            ser_active_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            // Accept and load never coincide: sym_ready is low while the buffer is full.
            if (accept_s) begin
                buf_full_r <= 1'b1;
                buf_len_r  <= sym_len(gen_speed);
            end else if (load_s) begin
                buf_full_r <= 1'b0;
            end else begin
                buf_full_r <= buf_full_r;
            end

            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r      <= SHIFT;
                        cur_len_r    <= buf_len_r;
                        bit_cnt_r    <= 8'd0;
                        ser_active_r <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SHIFT: begin
                    if (load_s) begin
                        cur_len_r <= buf_len_r;
                        bit_cnt_r <= 8'd0;
                    end else if (clear_s) begin
                        state_r      <= IDLE;
                        bit_cnt_r    <= 8'd0;
                        ser_active_r <= 1'b0;
                        underrun_r   <= 1'b1;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    bit_cnt_r    <= 8'd0;
                    ser_active_r <= 1'b0;
                end
            endcase
        end
    end

    lane_shift_reg #(.MAX_SYM(MAX_SYM)) u_lane_0 (
        .clk     (ser_clk),
        .rst     (rst),
        .flush   (flush_s),
        .wr_en   (accept_s),
        .load    (load_s),
        .shift   (shift_s),
        .clear   (clear_s),
        .sym_in  (lane_0_tx_enc_old),
        .ser_bit (lane_0_ser)
    );

    lane_shift_reg #(.MAX_SYM(MAX_SYM)) u_lane_1 (
        .clk     (ser_clk),
        .rst     (rst),
        .flush   (flush_s),
        .wr_en   (accept_s),
        .load    (load_s),
        .shift   (shift_s),
        .clear   (clear_s),
        .sym_in  (lane_1_tx_enc_old),
        .ser_bit (lane_1_ser)
    );

    assign ser_active = ser_active_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: a queue-of-bits reference model checked every cycle,
// plus directed checks of the documented scenarios and a randomized stream.
module tb_lane_serializer;

    logic         ser_clk = 1'b0;
    logic         rst;
    logic         enable_ser;
    logic [1:0]   gen_speed;
    logic [131:0] l0;
    logic [131:0] l1;
    logic         sym_valid;
    logic         sym_ready;
    logic         lane_0_ser;
    logic         lane_1_ser;
    logic         ser_active;
    logic         underrun;

    int total = 0;
    int bad   = 0;

    // Reference model: the bit stream currently on the wire plus one buffered symbol.
    bit q0[$];
    bit q1[$];
    bit b0[$];
    bit b1[$];
    bit m_buf;
    bit m_und;
    bit cap0[$];
    bit cap1[$];

    lane_serializer #(.MAX_SYM(132)) dut (
        .ser_clk           (ser_clk),
        .rst               (rst),
        .enable_ser        (enable_ser),
        .gen_speed         (gen_speed),
        .lane_0_tx_enc_old (l0),
        .lane_1_tx_enc_old (l1),
        .sym_valid         (sym_valid),
        .sym_ready         (sym_ready),
        .lane_0_ser        (lane_0_ser),
        .lane_1_ser        (lane_1_ser),
        .ser_active        (ser_active),
        .underrun          (underrun)
    );

    always #5 ser_clk = ~ser_clk;

    function automatic int len_of(input logic [1:0] g);
        if (g == 2'd0) return 8;
        else if (g == 2'd1) return 132;
        else return 66;
    endfunction

    function automatic logic [131:0] rnd();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[131:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); b0.delete(); b1.delete();
        m_buf = 1'b0;
        m_und = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = sym_valid && enable_ser && !m_buf;
        if (!enable_ser) begin
            model_reset();
            return;
        end
        if (q0.size() > 1) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end else begin
            if (q0.size() == 1 && !m_buf) m_und = 1'b1;
            q0.delete(); q1.delete();
            if (m_buf) begin
                q0 = b0;
                q1 = b1;
                m_buf = 1'b0;
            end
        end
        if (acc) begin
            b0.delete(); b1.delete();
            for (int i = 0; i < len_of(gen_speed); i++) begin
                b0.push_back(l0[i]);
                b1.push_back(l1[i]);
            end
            m_buf = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("lane_0_ser", {31'd0, lane_0_ser}, {31'd0, (q0.size() > 0) ? q0[0] : 1'b0});
        chk("lane_1_ser", {31'd0, lane_1_ser}, {31'd0, (q1.size() > 0) ? q1[0] : 1'b0});
        chk("ser_active", {31'd0, ser_active}, {31'd0, q0.size() > 0});
        chk("underrun",   {31'd0, underrun},   {31'd0, m_und});
        chk("sym_ready",  {31'd0, sym_ready},  {31'd0, enable_ser && !m_buf});
        if (ser_active) begin
            cap0.push_back(lane_0_ser);
            cap1.push_back(lane_1_ser);
        end
    endtask

    task automatic tick();
        @(posedge ser_clk);
        if (!rst) model_edge();
        @(negedge ser_clk);
        check_all();
    endtask

    task automatic offer(input logic [1:0] g, input logic [131:0] d0, input logic [131:0] d1);
        bit rdy;
        bit done;
        done = 1'b0;
        gen_speed = g;
        l0 = d0;
        l1 = d1;
        sym_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rdy = enable_ser && !m_buf;
            tick();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        sym_valid = 1'b0;
        if (!done) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic flush();
        enable_ser = 1'b0;
        tick();
        enable_ser = 1'b1;
        tick();
        cap0.delete();
        cap1.delete();
    endtask

    task automatic run_until_bit(input int n);
        for (int i = 0; i < 200 && cap0.size() < n; i++) tick();
        chk("reach_bit", cap0.size(), n);
    endtask

    initial begin
        logic [131:0] da;
        logic [131:0] db;
        logic [7:0]   e3c;

        rst = 1'b1; enable_ser = 1'b0; gen_speed = 2'd2;
        l0 = '0; l1 = '0; sym_valid = 1'b0;
        model_reset();
        #3;
        check_all();
        enable_ser = 1'b1;
        #1;
        check_all();
        @(negedge ser_clk);
        rst = 1'b0;
        tick();

        // Gen2 single symbol
        cap0.delete(); cap1.delete();
        da = rnd();
        da[65:0] = {64'hA5A5_0000_FFFF_1234, 2'b01};
        offer(2'd2, da, rnd());
        repeat (70) tick();
        chk("gen2_len", cap0.size(), 66);
        chk("gen2_bit0", {31'd0, cap0[0]}, 32'd1);
        chk("gen2_bit1", {31'd0, cap0[1]}, 32'd0);
        chk("gen2_underrun", {31'd0, underrun}, 32'd1);

        // Gen1 back-to-back
        flush();
        da = rnd(); da[3:0] = 4'b0101;
        db = rnd(); db[3:0] = 4'b1010;
        offer(2'd1, da, rnd());
        offer(2'd1, db, rnd());
        repeat (262) tick();
        chk("gen1_no_underrun_yet", {31'd0, underrun}, 32'd0);
        repeat (10) tick();
        chk("gen1_len", cap0.size(), 264);
        chk("gen1_hdr_a0", {31'd0, cap0[0]}, 32'd1);
        chk("gen1_hdr_b0", {31'd0, cap0[132]}, 32'd0);
        chk("gen1_hdr_b1", {31'd0, cap0[133]}, 32'd1);
        chk("gen1_underrun", {31'd0, underrun}, 32'd1);

        // Gen0 raw bytes, upper bits random and ignored
        flush();
        da = rnd(); da[7:0] = 8'h3C;
        db = rnd(); db[7:0] = 8'hC3;
        offer(2'd0, da, db);
        repeat (12) tick();
        chk("gen0_len", cap0.size(), 8);
        e3c = 8'h3C;
        for (int i = 0; i < 8 && i < cap0.size(); i++) begin
            chk("gen0_lane0", {31'd0, cap0[i]}, {31'd0, e3c[i]});
            chk("gen0_lane1_compl", {31'd0, cap1[i]}, {31'd0, ~cap0[i]});
        end

        // Mid-symbol disable at bit 30
        flush();
        offer(2'd2, rnd(), rnd());
        run_until_bit(31);
        enable_ser = 1'b0;
        tick();
        chk("dis_lane0", {31'd0, lane_0_ser}, 32'd0);
        chk("dis_active", {31'd0, ser_active}, 32'd0);
        chk("dis_ready", {31'd0, sym_ready}, 32'd0);
        chk("dis_underrun", {31'd0, underrun}, 32'd0);
        enable_ser = 1'b1;
        tick();
        cap0.delete(); cap1.delete();
        da = rnd();
        offer(2'd2, da, rnd());
        repeat (70) tick();
        chk("reen_len", cap0.size(), 66);
        chk("reen_bit0", {31'd0, cap0[0]}, {31'd0, da[0]});

        // Speed change mid-symbol
        flush();
        da = rnd();
        db = rnd();
        offer(2'd2, da, rnd());
        repeat (3) tick();
        gen_speed = 2'd1;
        repeat (3) tick();
        offer(2'd1, db, rnd());
        repeat (210) tick();
        chk("spd_len", cap0.size(), 198);
        chk("spd_a_last", {31'd0, cap0[65]}, {31'd0, da[65]});
        chk("spd_b_first", {31'd0, cap0[66]}, {31'd0, db[0]});
        chk("spd_b_last", {31'd0, cap0[197]}, {31'd0, db[131]});

        // Async reset at bit 50
        flush();
        offer(2'd3, rnd(), rnd());
        run_until_bit(51);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_lane0", {31'd0, lane_0_ser}, 32'd0);
        chk("rst_active", {31'd0, ser_active}, 32'd0);
        @(negedge ser_clk);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'd0, sym_ready}, 32'd1);

        // Randomized stream with occasional flushes and gaps
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                enable_ser = 1'b0;
                tick();
                enable_ser = 1'b1;
            end
            offer(2'($urandom_range(0, 3)), rnd(), rnd());
            repeat ($urandom_range(0, 4)) tick();
        end
        repeat (140) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
